// File: rtl/pll_lock_sequencer.sv
// Power-up / re-lock sequencer for the ECP5 EHXPLLL feeding the 60 MHz display domain.
// Optional standby support is compiled in when PLL_STDBY_EN is defined.
module pll_lock_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 12000,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES   = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_lock,
  input  logic       stdby_req,
  output logic       pll_rst,
  output logic       pll_stdby,
  output logic       domain_reset_n,
  output logic       locked,
  output logic       fault,
  output logic [7:0] relock_count
);

  localparam int unsigned RET_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RET_W-1:0] RET_LAST = RET_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
`ifdef PLL_STDBY_EN
    S_STDBY     = 3'd4,
`endif
    S_FAULT     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RET_W-1:0] retries_q, retries_d;
  logic [7:0]       relock_q, relock_d;
  logic             sync1_q, sync2_q;
  logic             lock_s;

  logic pll_rst_q, pll_rst_d;
  logic pll_stdby_q, pll_stdby_d;
  logic dom_rst_n_q, dom_rst_n_d;
  logic locked_q, locked_d;
  logic fault_q, fault_d;

`ifndef PLL_STDBY_EN
  logic unused_stdby_req;
  assign unused_stdby_req = stdby_req;
`endif

  // LOCK is asynchronous to the reference clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end

  assign lock_s = sync2_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    retries_d = retries_q;
    relock_d  = relock_q;

    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a timeout landing on the same cycle.
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          retries_d = retries_q + 1'b1;
          state_d   = (retries_q == RET_LAST) ? S_FAULT : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = '0;
        if (!lock_s) begin
          state_d = S_PLL_RST;
          if (relock_q != '1) relock_d = relock_q + 1'b1;
        end
`ifdef PLL_STDBY_EN
        else if (stdby_req) begin
          state_d = S_STDBY;
        end
`endif
      end
`ifdef PLL_STDBY_EN
      S_STDBY: begin
        cnt_d = '0;
        if (!stdby_req) state_d = S_PLL_RST;
      end
`endif
      S_FAULT: begin
        cnt_d = '0;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    pll_rst_d   = (state_d == S_PLL_RST) || (state_d == S_FAULT);
    dom_rst_n_d = (state_d == S_RUN);
    locked_d    = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
`ifdef PLL_STDBY_EN
    // Standby only after one full cycle in S_STDBY, so the domain reset lands first.
    pll_stdby_d = (state_d == S_STDBY) && (state_q == S_STDBY);
`else
    pll_stdby_d = 1'b0;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      retries_q   <= '0;
      relock_q    <= '0;
      pll_rst_q   <= 1'b1;
      pll_stdby_q <= 1'b0;
      dom_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retries_q   <= retries_d;
      relock_q    <= relock_d;
      pll_rst_q   <= pll_rst_d;
      pll_stdby_q <= pll_stdby_d;
      dom_rst_n_q <= dom_rst_n_d;
      locked_q    <= locked_d;
      fault_q     <= fault_d;
    end
  end

  assign pll_rst        = pll_rst_q;
  assign pll_stdby      = pll_stdby_q;
  assign domain_reset_n = dom_rst_n_q;
  assign locked         = locked_q;
  assign fault          = fault_q;
  assign relock_count   = relock_q;

endmodule
